serial_add_ctrl: RTL and testbench

//   Sequencer that performs a 4*NIBBLES-bit addition on one shared, registered 4-bit

---
 rtl/adder_pkg.sv | 15 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// adder_pkg: nibble width and sequencer state encoding shared by serial_add_ctrl.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// serial_add_ctrl: runs a 4*NIBBLES-bit add through one shared registered 4-bit adder,
// LSB nibble first, chaining the carry between nibbles.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_a_i,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_b_i,
    input  logic                         req_cin_i,
    output logic [NIBBLE_W-1:0]          add_a_o,
    output logic [NIBBLE_W-1:0]          add_b_o,
    output logic                         add_cin_o,
    input  logic [NIBBLE_W-1:0]          add_sum_i,
    input  logic                         add_cout_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_sum_o,
    output logic                         rsp_cout_o
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [1:0]       CNT_LOAD = 2'(ADD_LAT - 1);

    state_t               state_q;
    logic [W-1:0]         a_q, b_q, sum_q;
    logic [W-1:0]         a_d, b_d;
    logic [IDX_W-1:0]     idx_q;
    logic [1:0]           cnt_q;
    logic                 cout_q, req_ready_q, rsp_valid_q;
    logic [NIBBLE_W-1:0]  add_a_q, add_b_q;
    logic                 add_cin_q;

    // Operands shift down one nibble per step, so the next nibble is always at the bottom.
    assign a_d = a_q >> NIBBLE_W;
    assign b_d = b_q >> NIBBLE_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q         <= req_a_i;
                        b_q         <= req_b_i;
                        idx_q       <= '0;
                        add_a_q     <= req_a_i[NIBBLE_W-1:0];
                        add_b_q     <= req_b_i[NIBBLE_W-1:0];
                        add_cin_q   <= req_cin_i;
                        req_ready_q <= 1'b0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= add_sum_i;
                        if (idx_q == IDX_LAST) begin
                            cout_q      <= add_cout_i;
                            rsp_valid_q <= 1'b1;
                            add_a_q     <= '0;
                            add_b_q     <= '0;
                            add_cin_q   <= 1'b0;
                            state_q     <= DONE;
                        end else begin
                            // The running carry lives in add_cin_q while a nibble is in flight.
                            idx_q     <= idx_q + 1'b1;
                            a_q       <= a_d;
                            b_q       <= b_d;
                            add_a_q   <= a_d[NIBBLE_W-1:0];
                            add_b_q   <= b_d[NIBBLE_W-1:0];
                            add_cin_q <= add_cout_i;
                            state_q   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = cout_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_cin_o   = add_cin_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// Directed bench: two controllers (ADD_LAT=1 and 2), each beside a registered 4-bit adder model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, req_valid, req_cin, rsp_ready;
    logic [15:0] req_a, req_b;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        rr1, rv1, cin1, cout1, rc1;
    logic [3:0]  a1, b1, sum1;
    logic [15:0] rs1;
    logic        rr2, rv2, cin2, cout2, rc2;
    logic [3:0]  a2, b2, sum2;
    logic [15:0] rs2;

    logic [4:0]  m1, m2a, m2b;
    always_ff @(posedge clk) begin
        m1  <= {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
        m2a <= {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};
        m2b <= m2a;
    end
    assign sum1 = m1[3:0];
    assign cout1 = m1[4];
    assign sum2 = m2b[3:0];
    assign cout2 = m2b[4];

    serial_add_ctrl #(.NIBBLES(4), .ADD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid & ~sel), .req_ready_o(rr1),
        .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
        .add_a_o(a1), .add_b_o(b1), .add_cin_o(cin1),
        .add_sum_i(sum1), .add_cout_i(cout1),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready & ~sel),
        .rsp_sum_o(rs1), .rsp_cout_o(rc1)
    );

    serial_add_ctrl #(.NIBBLES(4), .ADD_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid & sel), .req_ready_o(rr2),
        .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
        .add_a_o(a2), .add_b_o(b2), .add_cin_o(cin2),
        .add_sum_i(sum2), .add_cout_i(cout2),
        .rsp_valid_o(rv2), .rsp_ready_i(rsp_ready & sel),
        .rsp_sum_o(rs2), .rsp_cout_o(rc2)
    );

    wire        req_ready = sel ? rr2 : rr1;
    wire        rsp_valid = sel ? rv2 : rv1;
    wire [15:0] rsp_sum   = sel ? rs2 : rs1;
    wire        rsp_cout  = sel ? rc2 : rc1;
    wire [3:0]  add_a     = sel ? a2 : a1;
    wire [3:0]  add_b     = sel ? b2 : b1;
    wire        add_cin   = sel ? cin2 : cin1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge; records add_a/add_cin in each ISSUE cycle.
    task automatic wait_rsp(input int L, input int exp_lat,
                            output logic [15:0] sa, output logic [3:0] sc);
        int lat;
        lat = 0;
        sa  = '0;
        sc  = '0;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            if ((lat % (L + 1)) == 0 && (lat / (L + 1)) < 4) begin
                sa[4*(lat/(L+1)) +: 4] = add_a;
                sc[lat/(L+1)]          = add_cin;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_req", req_ready, 1'b1);
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic respond();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 1'b0);
        check("req_ready_after_hs", req_ready, 1'b1);
    endtask

    logic [15:0] sa;
    logic [3:0]  sc;
    logic        seen;

    initial begin
        sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_cin = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_add_a", add_a, 4'h0);
        check("rst_add_b", add_b, 4'h0);
        check("rst_add_cin", add_cin, 1'b0);
        check("rst_rsp_sum", rsp_sum, 16'h0000);
        check("rst_rsp_cout", rsp_cout, 1'b0);

        // 2-4 at ADD_LAT=1 (sel=0) then ADD_LAT=2 (sel=1)
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            accept(16'h1234, 16'h1111, 1'b0);
            wait_rsp(s + 1, (s == 0) ? 8 : 12, sa, sc);
            check("t2_sum", rsp_sum, 16'h2345);
            check("t2_cout", rsp_cout, 1'b0);
            check("t2_add_a_seq", sa, 16'h1234);
            check("t2_add_cin_seq", sc, 4'b0000);
            check("t2_add_a_done", add_a, 4'h0);
            check("t2_add_b_done", add_b, 4'h0);
            respond();

            accept(16'hFFFF, 16'h0001, 1'b0);
            wait_rsp(s + 1, (s == 0) ? 8 : 12, sa, sc);
            check("t3_sum", rsp_sum, 16'h0000);
            check("t3_cout", rsp_cout, 1'b1);
            check("t3_add_cin_seq", sc, 4'b1110);
            respond();

            accept(16'hFFFF, 16'hFFFF, 1'b1);
            wait_rsp(s + 1, (s == 0) ? 8 : 12, sa, sc);
            check("t4_sum", rsp_sum, 16'hFFFF);
            check("t4_cout", rsp_cout, 1'b1);
            check("t4_add_cin_seq", sc, 4'b1111);
            respond();
        end
        sel = 1'b0;

        // 5. back-pressure in DONE with a pending request
        accept(16'hABCD, 16'h1234, 1'b0);
        wait_rsp(1, 8, sa, sc);
        req_a = 16'h0F0F; req_b = 16'h00F1; req_cin = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_sum", rsp_sum, 16'hBE01);
            check("t5_hold_cout", rsp_cout, 1'b0);
            check("t5_hold_ready", req_ready, 1'b0);
            check("t5_hold_valid", rsp_valid, 1'b1);
        end
        respond();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_next_accepted", req_ready, 1'b0);
        wait_rsp(1, 8, sa, sc);
        check("t5_sum", rsp_sum, 16'h1001);
        check("t5_cout", rsp_cout, 1'b0);
        respond();

        // 6. reset mid-operation
        accept(16'h5555, 16'h5555, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", rsp_valid, 1'b0);
        check("t6_rst_ready", req_ready, 1'b1);
        check("t6_rst_sum", rsp_sum, 16'h0000);
        check("t6_rst_add_a", add_a, 4'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        check("t6_no_rsp", seen, 1'b0);
        accept(16'h0001, 16'h0001, 1'b0);
        wait_rsp(1, 8, sa, sc);
        check("t6_sum", rsp_sum, 16'h0002);
        check("t6_cout", rsp_cout, 1'b0);
        respond();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
